// File: rtl/load_store_unit.sv
// Load/store unit: byte-lane alignment, load extension and two-beat split of word-crossing accesses.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with resp_err instead of splitting.
module load_store_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  typedef enum logic [1:0] {StIdle, StBeat1, StBeat2, StDone} state_e;
  state_e state_q, state_d;

  logic [OFF_W-1:0]  off;
  logic [2:0]        size;
  logic [3:0]        bmask;
  logic [31:0]       wmask;
  logic              legal, misalign, reject, split, accept;
  logic [NB-1:0]     be1, be2;
  logic [DATA_W-1:0] wd1, wd2;
  int unsigned       hi_shift;

  logic                we_q, split_q, err_q;
  logic [2:0]          funct3_q;
  logic [OFF_W-1:0]    off_q;
  logic [NB-1:0]       be_q, be2_q;
  logic [DATA_W-1:0]   wdata_q, wd2_q, buf_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         rdata_q;
  logic [2*DATA_W-1:0] rd_src;
  logic [31:0]         rd_bytes, rd_ext;

  assign off    = req_addr[OFF_W-1:0];
  assign accept = (state_q == StIdle) && req_valid;

  always_comb begin
    legal = 1'b1;
    size  = 3'd1;
    bmask = 4'h1;
    wmask = 32'h0000_00ff;
    case (req_funct3)
      3'd0, 3'd4: begin end
      3'd1, 3'd5: begin
        size  = 3'd2;
        bmask = 4'h3;
        wmask = 32'h0000_ffff;
      end
      3'd2: begin
        size  = 3'd4;
        bmask = 4'hf;
        wmask = 32'hffff_ffff;
      end
      default: legal = 1'b0;
    endcase
    // Unsigned variants exist only for loads.
    if (req_we && req_funct3[2]) legal = 1'b0;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = |(off & OFF_W'(size - 3'd1));
`else
  assign misalign = 1'b0;
`endif

  assign reject   = !legal || misalign;
  assign split    = (32'(off) + 32'(size)) > NB;
  assign hi_shift = DATA_W - 32'(off) * 8;

  // Beat 2 carries the bytes that fall past the top lane, restarting at lane 0.
  assign be1 = NB'(bmask) << off;
  assign be2 = NB'(bmask) >> (NB - 32'(off));
  assign wd1 = DATA_W'(req_wdata) << {off, 3'b000};
  assign wd2 = DATA_W'(req_wdata & wmask) >> hi_shift;

  assign rd_src   = (state_q == StBeat2) ? {mem_rdata, buf_q} : {{DATA_W{1'b0}}, mem_rdata};
  assign rd_bytes = 32'(rd_src >> {off_q, 3'b000});

  always_comb begin
    rd_ext = rd_bytes;
    case (funct3_q)
      3'd0:    rd_ext = {{24{rd_bytes[7]}}, rd_bytes[7:0]};
      3'd1:    rd_ext = {{16{rd_bytes[15]}}, rd_bytes[15:0]};
      3'd4:    rd_ext = {24'd0, rd_bytes[7:0]};
      3'd5:    rd_ext = {16'd0, rd_bytes[15:0]};
      default: rd_ext = rd_bytes;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_valid) state_d = reject ? StDone : StBeat1;
      StBeat1: if (mem_resp) state_d = split_q ? StBeat2 : StDone;
      StBeat2: if (mem_resp) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'd0;
      off_q    <= '0;
      be_q     <= '0;
      be2_q    <= '0;
      wdata_q  <= '0;
      wd2_q    <= '0;
      buf_q    <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        off_q    <= off;
        split_q  <= split;
        err_q    <= reject;
        rdata_q  <= '0;
        if (!reject) begin
          addr_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          be_q    <= be1;
          wdata_q <= wd1;
          be2_q   <= be2;
          wd2_q   <= wd2;
        end
      end
      if (state_q == StBeat1 && mem_resp) begin
        if (split_q) begin
          buf_q   <= mem_rdata;
          addr_q  <= addr_q + ADDR_W'(NB);
          be_q    <= be2_q;
          wdata_q <= wd2_q;
        end else if (!we_q) begin
          rdata_q <= rd_ext;
        end
      end
      if (state_q == StBeat2 && mem_resp && !we_q) rdata_q <= rd_ext;
    end
  end

  assign req_ready       = (state_q == StIdle);
  assign mem_read        = (state_q == StBeat1 || state_q == StBeat2) && !we_q;
  assign mem_write       = (state_q == StBeat1 || state_q == StBeat2) && we_q;
  assign mem_address     = addr_q;
  assign mem_byte_enable = be_q;
  assign mem_wdata       = wdata_q;
  assign resp_valid      = (state_q == StDone);
  assign resp_err        = resp_valid && err_q;
  assign resp_rdata      = resp_valid ? rdata_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory responder plus a byte-level reference model.
module tb_load_store_unit;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read, mem_write, mem_resp;
  logic [NB-1:0]     mem_byte_enable;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  load_store_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] dmem [0:1023];
  int resp_wait     = 0;
  int both_strobes  = 0;
  int strobe_cycles = 0;
  logic [ADDR_W-1:0] log_addr[$];
  logic [NB-1:0]     log_be[$];
  logic [DATA_W-1:0] log_data[$];
  logic              log_wr[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: answers each strobed beat after resp_wait idle strobe cycles.
  initial begin : responder
    int cnt;
    cnt = -1;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (mem_read && mem_write) both_strobes++;
      if (mem_read || mem_write) begin
        strobe_cycles++;
        if (cnt < 0) cnt = resp_wait;
        if (cnt == 0) begin
          mem_resp = 1'b1;
          for (int j = 0; j < NB; j++) begin
            mem_rdata[8*j +: 8] = dmem[(int'(mem_address[9:0]) + j) & 1023];
            if (mem_write && mem_byte_enable[j])
              dmem[(int'(mem_address[9:0]) + j) & 1023] = mem_wdata[8*j +: 8];
          end
          log_addr.push_back(mem_address);
          log_be.push_back(mem_byte_enable);
          log_data.push_back(mem_wdata);
          log_wr.push_back(mem_write);
          cnt = -1;
        end else begin
          cnt--;
        end
      end else begin
        cnt = -1;
      end
    end
  end

  task automatic set_word(input int a, input logic [31:0] v);
    for (int j = 0; j < 4; j++) dmem[(a + j) & 1023] = v[8*j +: 8];
  endtask

  function automatic logic [DATA_W-1:0] expand(input logic [NB-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int j = 0; j < NB; j++) if (be[j]) m[8*j +: 8] = 8'hff;
    return m;
  endfunction

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic err);
    int guard;
    log_addr.delete();
    log_be.delete();
    log_data.delete();
    log_wr.delete();
    guard = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    rd  = '0;
    err = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = c;
        rd  = resp_rdata;
        err = resp_err;
        break;
      end
    end
    check("resp_seen", lat != 0, 1'b1);
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 1'b0);
  endtask

  // Reference: walk the accessed bytes one at a time and group them by bus word.
  task automatic run_check(input string tag, input logic we, input logic [2:0] f3,
                           input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd_out, output int lat_out);
    int size, off, nbeats, lane;
    bit ok, mis;
    logic [31:0] exp_rd, rd;
    logic [ADDR_W-1:0] a, w;
    logic [ADDR_W-1:0] ea [2];
    logic [NB-1:0]     eb [2];
    logic [DATA_W-1:0] ed [2];
    logic err;
    int lat;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    ok  = (size != 0) && !(we && f3[2]);
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (ok && (int'(addr % size) != 0)) mis = 1'b1;
`endif
    off    = int'(addr % NB);
    exp_rd = '0;
    nbeats = 0;
    for (int k = 0; k < 2; k++) begin
      ea[k] = '0;
      eb[k] = '0;
      ed[k] = '0;
    end
    if (ok && !mis) begin
      for (int i = 0; i < size; i++) begin
        a    = addr + ADDR_W'(i);
        w    = a - (a % NB);
        lane = int'(a % NB);
        if (nbeats == 0 || ea[nbeats-1] != w) begin
          ea[nbeats] = w;
          nbeats++;
        end
        eb[nbeats-1][lane] = 1'b1;
        if (!we) exp_rd = exp_rd | (32'(dmem[a[9:0]]) << (8 * i));
        else if (nbeats == 2) ed[1][8*lane +: 8] = wd[8*i +: 8];
      end
      if (we) begin
        for (int j = off; j < NB; j++)
          if (j - off < 4) ed[0][8*j +: 8] = wd[8*(j-off) +: 8];
      end
      if (f3 == 3'd0) exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
      if (f3 == 3'd1) exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
    end
    do_txn(we, f3, addr, wd, lat, rd, err);
    check({tag, "_err"}, err, !(ok && !mis));
    if (ok && !mis && !we) check({tag, "_rdata"}, rd, exp_rd);
    if (we) check({tag, "_store_rdata"}, rd, 32'd0);
    check({tag, "_nbeats"}, log_addr.size(), nbeats);
    for (int k = 0; k < nbeats; k++) begin
      if (k < log_addr.size()) begin
        check({tag, "_beat_addr"}, log_addr[k], ea[k]);
        check({tag, "_beat_be"}, log_be[k], eb[k]);
        check({tag, "_beat_dir"}, log_wr[k], we);
        if (we && k == 0) check({tag, "_beat1_data"}, log_data[k], ed[k]);
        if (we && k == 1) check({tag, "_beat2_data"}, log_data[k] & expand(eb[k]), ed[k]);
      end
    end
    rd_out  = rd;
    lat_out = lat;
  endtask

  initial begin
    logic [31:0] rd;
    int lat, sc, rv_seen;
    logic we;
    logic [2:0] f3;
    int idx;

    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 1024; i++) dmem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_be", mem_byte_enable, '0);
    rst = 1'b0;

    set_word(32'h100, 32'hDEADBEEF);
    resp_wait = 2;
    sc = strobe_cycles;
    run_check("lw_aligned", 1'b0, 3'd2, 32'h100, 32'h0, rd, lat);
    check("lw_aligned_val", rd, 32'hDEADBEEF);
    check("lw_aligned_strobes", strobe_cycles - sc, 3);

    resp_wait = 0;
    run_check("lw_latency", 1'b0, 3'd2, 32'h100, 32'h0, rd, lat);
    check("lw_latency_cycles", lat, 2);

    set_word(32'h100, 32'h80112233);
    run_check("lb", 1'b0, 3'd0, 32'h103, 32'h0, rd, lat);
    check("lb_val", rd, 32'hFFFFFF80);
    run_check("lbu", 1'b0, 3'd4, 32'h103, 32'h0, rd, lat);
    check("lbu_val", rd, 32'h00000080);

    run_check("sh", 1'b1, 3'd1, 32'h102, 32'h0000ABCD, rd, lat);
    check("sh_data", log_data[0], 32'hABCD0000);
    check("sh_be", log_be[0], 4'b1100);

    set_word(32'h100, 32'h44332211);
    set_word(32'h104, 32'h88776655);
    sc = strobe_cycles;
    run_check("lw_split", 1'b0, 3'd2, 32'h102, 32'h0, rd, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_split_trap_nostrobe", strobe_cycles - sc, 0);
`else
    check("lw_split_val", rd, 32'h66554433);
    check("lw_split_latency", lat >= 3, 1'b1);
`endif

    run_check("sw_split", 1'b1, 3'd2, 32'h103, 32'h11223344, rd, lat);
`ifndef LSU_MISALIGN_TRAP_EN
    check("sw_split_b1_addr", log_addr[0], 32'h100);
    check("sw_split_b1_be", log_be[0], 4'b1000);
    check("sw_split_b1_data", log_data[0], 32'h44000000);
    check("sw_split_b2_addr", log_addr[1], 32'h104);
    check("sw_split_b2_be", log_be[1], 4'b0111);
    check("sw_split_b2_data", log_data[1], 32'h00112233);
`endif

    sc = strobe_cycles;
    run_check("illegal_f3", 1'b0, 3'd3, 32'h110, 32'h0, rd, lat);
    check("illegal_nostrobe", strobe_cycles - sc, 0);
    check("illegal_latency", lat >= 1 && lat <= 2, 1'b1);
    run_check("illegal_store", 1'b1, 3'd4, 32'h110, 32'h12345678, rd, lat);

    // Reset while the first beat is outstanding.
    resp_wait = 6;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_funct3 = 3'd2;
    req_addr = 32'h140;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("beat1_read", mem_read, 1'b1);
    check("beat1_not_ready", req_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_read", mem_read, 1'b0);
    check("rst_mid_write", mem_write, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) rv_seen++;
    end
    check("rst_mid_no_resp", rv_seen, 0);
    check("rst_mid_ready", req_ready, 1'b1);
    resp_wait = 0;
    run_check("lw_after_rst", 1'b0, 3'd2, 32'h140, 32'h0, rd, lat);

    // A request presented while busy must be ignored.
    resp_wait = 4;
    fork
      run_check("sw_busy", 1'b1, 3'd2, 32'h180, 32'hCAFEF00D, rd, lat);
      begin
        repeat (3) @(negedge clk);
        check("busy_not_ready", req_ready, 1'b0);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'd3;
        req_addr = 32'h1C1;
        @(negedge clk);
        req_valid = 1'b0;
      end
    join
    sc = strobe_cycles;
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) rv_seen++;
    end
    check("busy_ignored_strobes", strobe_cycles - sc, 0);
    check("busy_ignored_resp", rv_seen, 0);

    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        f3 = 3'($urandom_range(0, 7));
      end else if (we) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        idx = int'($urandom_range(0, 4));
        f3 = (idx < 3) ? 3'(idx) : 3'(idx + 1);
      end
      resp_wait = int'($urandom_range(0, 2));
      run_check("rnd", we, f3, ADDR_W'(32'h100 + $urandom_range(0, 32'hF0)), $urandom, rd, lat);
    end

    check("no_dual_strobe", both_strobes, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
